// File: rtl/barrel_dispatcher_pkg.sv
// Shared definitions for the barrel dispatcher slice: barrel and dispatcher state encodings.
// Latency: none (types and constants only).
// Backpressure: none.
package barrel_dispatcher_pkg;

    // Default number of barrel slots in the bank.
    localparam int SLOT_NUM_DEFAULT = 16;

    // Per-barrel life cycle as reported by the barrel instances.
    typedef enum logic [1:0] {
        BARREL_INITIAL = 2'b00,
        BARREL_ROLLING = 2'b01,
        BARREL_FALLING = 2'b10
    } barrel_state_e;

    // Dispatcher FSM: waiting for a drop, or holding a start until the slot acknowledges.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } disp_state_e;

endpackage

// File: rtl/barrel_dispatcher_rr_free_finder.sv
// Round-robin free-slot search: first idle slot at or after rr_ptr, wrapping modulo SLOT_NUM.
// Latency: purely combinational.
// Backpressure: none; found_o low means every slot is busy.
module barrel_dispatcher_rr_free_finder #(
    parameter int SLOT_NUM = 16,
    parameter int IDX_W    = 4
) (
    input  logic [SLOT_NUM-1:0] slot_busy_i,
    input  logic [IDX_W-1:0]    rr_ptr_i,
    output logic                found_o,
    output logic [IDX_W-1:0]    idx_o
);

    // Scan from the farthest offset down so the nearest free slot is the one that sticks.
    always_comb begin
        int            j;
        logic [IDX_W-1:0] jj;
        found_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        jj      = '0;
        for (int k = SLOT_NUM - 1; k >= 0; k--) begin
            j = int'(rr_ptr_i) + k;
            if (j >= SLOT_NUM) begin
                j = j - SLOT_NUM;
            end
            jj = IDX_W'(j);
            if (!slot_busy_i[jj]) begin
                found_o = 1'b1;
                idx_o   = jj;
            end
        end
    end

endmodule

// File: rtl/barrel_dispatcher.sv
// Dispatches kong drop events to free barrel slots round-robin, holding a one-hot start until busy.
// Latency: drop edge -> pending at that edge; start one edge later if a slot is free.
// Backpressure: one-deep pending; extra edges are dropped (counted when BARREL_DISPATCH_STATS_EN).
module barrel_dispatcher
    import barrel_dispatcher_pkg::*;
#(
    parameter int SLOT_NUM    = SLOT_NUM_DEFAULT,
    parameter int IDX_W       = 4,
    parameter int ACK_TIMEOUT = 1048576,
    parameter int TO_W        = 21
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                drop_req,
    input  logic [SLOT_NUM-1:0] slot_busy,
    output logic [SLOT_NUM-1:0] slot_start,
    output logic [IDX_W-1:0]    grant_idx,
    output logic [7:0]          drop_count,
    output logic                full,
    output logic [IDX_W:0]      active_count,
    output logic [7:0]          lost_count
);

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SLOT_NUM - 1);

    disp_state_e         state_q;
    logic                pending_q, pending_d;
    logic                drop_prev_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [TO_W-1:0]     to_q;
    logic [SLOT_NUM-1:0] slot_start_q;
    logic [IDX_W-1:0]    grant_idx_q;
    logic [7:0]          drop_count_q;
    logic                full_q;

    logic                rise;
    logic                found;
    logic [IDX_W-1:0]    free_idx;
    logic                consume;
    logic                acked;
    logic [IDX_W-1:0]    ptr_after;

    barrel_dispatcher_rr_free_finder #(
        .SLOT_NUM (SLOT_NUM),
        .IDX_W    (IDX_W)
    ) u_finder (
        .slot_busy_i (slot_busy),
        .rr_ptr_i    (rr_ptr_q),
        .found_o     (found),
        .idx_o       (free_idx)
    );

    // Edge detect, consume/ack decode and the pending flag's next value.
    always_comb begin
        rise      = drop_req & ~drop_prev_q;
        consume   = enable && (state_q == IDLE) && pending_q && found;
        acked     = slot_busy[grant_idx_q];
        ptr_after = (grant_idx_q == IDX_LAST) ? '0 : grant_idx_q + 1'b1;
        pending_d = pending_q;
        if (!enable) begin
            pending_d = 1'b0;
        end else if (rise) begin
            // A fresh edge re-arms even while the old request is being consumed.
            pending_d = 1'b1;
        end else if (consume) begin
            pending_d = 1'b0;
        end
    end

    // Pending latch and drop_req history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= 1'b0;
            drop_prev_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            drop_prev_q <= drop_req;
        end
    end

    // Grant FSM with registered start, index, round-robin pointer and grant counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            slot_start_q <= '0;
            grant_idx_q  <= '0;
            rr_ptr_q     <= '0;
            to_q         <= '0;
            drop_count_q <= '0;
        end else if (!enable) begin
            state_q      <= IDLE;
            slot_start_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pending_q && found) begin
                        slot_start_q <= SLOT_NUM'(1) << free_idx;
                        grant_idx_q  <= free_idx;
                        to_q         <= '0;
                        state_q      <= GRANT;
                    end
                end
                GRANT: begin
                    if (acked) begin
                        slot_start_q <= '0;
                        drop_count_q <= drop_count_q + 8'd1;
                        rr_ptr_q     <= ptr_after;
                        state_q      <= IDLE;
                    end else if (to_q == TO_LAST) begin
                        // Slot never came out of its initial state; abandon it and move on.
                        slot_start_q <= '0;
                        rr_ptr_q     <= ptr_after;
                        state_q      <= IDLE;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    slot_start_q <= '0;
                end
            endcase
        end
    end

    // All-busy flag, registered one cycle behind slot_busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
        end else begin
            full_q <= &slot_busy;
        end
    end

    assign slot_start = slot_start_q;
    assign grant_idx  = grant_idx_q;
    assign drop_count = drop_count_q;
    assign full       = full_q;

`ifdef BARREL_DISPATCH_STATS_EN
    logic [IDX_W:0] active_q, active_d;
    logic [7:0]     lost_q;
    logic           lost_evt;

    // Popcount of busy slots and detection of edges that find pending already occupied.
    always_comb begin
        active_d = '0;
        for (int i = 0; i < SLOT_NUM; i++) begin
            active_d = active_d + (IDX_W+1)'(slot_busy[i]);
        end
        lost_evt = enable && rise && pending_q && !consume;
    end

    // Statistics registers; lost count saturates at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= '0;
            lost_q   <= '0;
        end else begin
            active_q <= active_d;
            if (lost_evt && (lost_q != 8'hFF)) begin
                lost_q <= lost_q + 8'd1;
            end
        end
    end

    assign active_count = active_q;
    assign lost_count   = lost_q;
`else
    assign active_count = '0;
    assign lost_count   = '0;
`endif

endmodule

// File: tb/tb_barrel_dispatcher.sv
// Bench for barrel_dispatcher: directed scenarios plus random traffic against a cycle model.
// Latency: model advances on each rising clk, outputs compared on the falling edge.
// Backpressure: bench acknowledges grants by raising the granted slot's busy bit.
module tb_barrel_dispatcher;

    localparam int N  = 16;
    localparam int IW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          drop_req = 1'b0;
    logic [N-1:0]  slot_busy = '0;
    logic [N-1:0]  slot_start;
    logic [IW-1:0] grant_idx;
    logic [7:0]    drop_count;
    logic          full;
    logic [IW:0]   active_count;
    logic [7:0]    lost_count;

    int n_cmp = 0;
    int n_bad = 0;

    barrel_dispatcher #(
        .SLOT_NUM    (N),
        .IDX_W       (IW),
        .ACK_TIMEOUT (TO),
        .TO_W        (21)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .drop_req     (drop_req),
        .slot_busy    (slot_busy),
        .slot_start   (slot_start),
        .grant_idx    (grant_idx),
        .drop_count   (drop_count),
        .full         (full),
        .active_count (active_count),
        .lost_count   (lost_count)
    );

    always #5 clk = ~clk;

`ifdef BARREL_DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Behavioural model: plain integers describing the dispatcher's observable state.
    bit m_granting;
    bit m_pending;
    bit m_prev;
    int m_ptr, m_gidx, m_wait, m_drops, m_lost, m_active;
    bit m_full;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_granting = 0; m_pending = 0; m_prev = 0;
            m_ptr = 0; m_gidx = 0; m_wait = 0; m_drops = 0; m_lost = 0;
            m_active = 0; m_full = 0;
        end else begin
            bit rise, was_pending, consumed;
            rise = drop_req && !m_prev;
            was_pending = m_pending;
            consumed = 0;
            if (!enable) begin
                m_granting = 0;
                m_pending  = 0;
            end else begin
                if (m_granting) begin
                    if (slot_busy[m_gidx]) begin
                        m_granting = 0;
                        m_drops = (m_drops + 1) % 256;
                        m_ptr = (m_gidx + 1) % N;
                    end else if (m_wait == TO - 1) begin
                        m_granting = 0;
                        m_ptr = (m_gidx + 1) % N;
                    end else begin
                        m_wait++;
                    end
                end else if (was_pending) begin
                    for (int k = 0; k < N; k++) begin
                        if (!consumed && !slot_busy[(m_ptr + k) % N]) begin
                            consumed = 1;
                            m_gidx = (m_ptr + k) % N;
                        end
                    end
                    if (consumed) begin
                        m_granting = 1;
                        m_wait = 0;
                    end
                end
                if (rise) begin
                    if (was_pending && !consumed && STATS && m_lost < 255) m_lost++;
                    m_pending = 1;
                end else if (consumed) begin
                    m_pending = 0;
                end
            end
            m_full = &slot_busy;
            m_active = STATS ? $countones(slot_busy) : 0;
            m_prev = drop_req;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Continuous comparison of every output against the model.
    always @(negedge clk) begin
        int exp_start;
        exp_start = m_granting ? (1 << m_gidx) : 0;
        check("slot_start", int'(slot_start), exp_start);
        check("grant_idx", int'(grant_idx), m_gidx);
        check("drop_count", int'(drop_count), m_drops);
        check("full", int'(full), int'(m_full));
        check("active_count", int'(active_count), m_active);
        check("lost_count", int'(lost_count), m_lost);
        check("onehot", ($countones(slot_start) <= 1) ? 1 : 0, 1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drop pulse; afterwards a start is visible if a slot was free.
    task automatic pulse();
        drop_req = 1'b1;
        tick();
        drop_req = 1'b0;
        tick();
    endtask

    task automatic ack_current();
        slot_busy = slot_busy | slot_start;
        tick();
    endtask

    initial begin
        int cnt, g, d0;
        tick(); tick();
        check("reset_start", int'(slot_start), 0);
        check("reset_drops", int'(drop_count), 0);
        rst = 1'b0;
        enable = 1'b1;
        tick();

        // First grant from slot 0, ack, next grant to slot 1.
        pulse();
        check("first_start", int'(slot_start), 16'h0001);
        slot_busy = 16'h0001;
        tick();
        check("ack_drop", int'(slot_start), 0);
        check("ack_count", int'(drop_count), 1);
        slot_busy = '0;
        pulse();
        check("second_start", int'(slot_start), 16'h0002);
        ack_current();
        slot_busy = '0;
        for (int s = 2; s <= 4; s++) begin
            pulse();
            check("walk_idx", int'(grant_idx), s);
            ack_current();
            slot_busy = '0;
        end

        // rr_ptr=5, only slot 1 free: search wraps.
        slot_busy = 16'hFFFD;
        pulse();
        check("wrap_idx", int'(grant_idx), 1);
        check("wrap_start", int'(slot_start), 16'h0002);
        ack_current();

        // All busy: pending waits, then slot 7 released.
        slot_busy = 16'hFFFF;
        pulse();
        check("full_nostart", int'(slot_start), 0);
        check("full_flag", int'(full), 1);
        slot_busy = 16'hFF7F;
        tick();
        check("release_start", int'(slot_start), 16'h0080);
        ack_current();
        slot_busy = '0;
        tick();

        // Three edges during an unacknowledged grant: one pending, two lost.
        pulse();
        for (int e = 0; e < 3; e++) begin
            drop_req = 1'b1; tick();
            drop_req = 1'b0; tick();
        end
        check("lost_two", int'(lost_count), STATS ? 2 : 0);
        repeat (25) tick();

        // Timeout: start held exactly TO cycles, no drop counted.
        d0 = int'(drop_count);
        pulse();
        g = int'(grant_idx);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (slot_start != 0) cnt++;
            tick();
        end
        check("timeout_len", cnt, TO);
        check("timeout_drops", int'(drop_count), d0);
        pulse();
        check("after_timeout_idx", int'(grant_idx), (g + 1) % N);

        // Asynchronous reset mid-grant.
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("async_rst", int'(slot_start), 0);
        tick();
        rst = 1'b0;
        tick();

        // Enable low during grant clears start and pending.
        pulse();
        check("grant_before_en", int'(slot_start), 16'h0001);
        drop_req = 1'b1; tick();
        drop_req = 1'b0;
        enable = 1'b0;
        tick();
        check("en_low_start", int'(slot_start), 0);
        enable = 1'b1;
        repeat (5) tick();
        check("en_low_pending", int'(slot_start), 0);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            drop_req = ($urandom_range(0, 3) == 0);
            enable = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 7) == 0) slot_busy[$urandom_range(0, N-1)] = 1'b0;
            if ($urandom_range(0, 7) == 0) slot_busy[$urandom_range(0, N-1)] = 1'b1;
            if (slot_start != 0 && $urandom_range(0, 2) == 0) slot_busy = slot_busy | slot_start;
            if ($urandom_range(0, 199) == 0) slot_busy = '1;
            if ($urandom_range(0, 99) == 0) slot_busy = '0;
            tick();
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
